// File: rtl/uart_pkg.sv
// Shared types and constants for the message UART transmitter.
//   tx_state_t : transmitter FSM states
//   phase_t    : which part of the output is being sent (RAM message, CR, LF)
//   CHAR_CR / CHAR_LF : line terminator bytes appended after the message
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA,
        STOP_BIT,
        FINISH
    } tx_state_t;

    typedef enum logic [1:0] {
        MSG,
        CR,
        LF
    } phase_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: a down-counter that reloads to BIT_TICKS-1 on restart
// or after reaching zero.
//   clock   : system clock
//   reset   : asynchronous, active-high
//   restart : reload the counter so a new bit period begins next cycle
//   tick    : high on the final cycle of each bit period
module uart_baud_tick #(
    parameter int BIT_TICKS = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || count == '0) begin
            count <= CW'(BIT_TICKS - 1);
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/message_uart_tx.sv
// Reads the decrypted-message RAM from address 0 upward and sends each byte
// as an 8N1 UART frame, optionally followed by CR/LF, then pulses done.
//   clock       : system clock
//   reset       : asynchronous, active-high
//   start       : begin a transmission (sampled only while idle)
//   ram_address : RAM read address (holds the last fetched index)
//   ram_q       : RAM read data, valid two edges after ram_address changes
//   tx          : registered serial output, idles high
//   busy        : transmission in progress
//   done        : one-cycle pulse after the final stop bit
module message_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int MSG_LEN     = 32,
    parameter int ADDR_W      = 5,
    parameter int STOP_ON_NUL = 1,
    parameter int APPEND_CRLF = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [7:0]        ram_q,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    tx_state_t         state, state_next;
    phase_t            phase, phase_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic              tx_next;
    logic              restart;
    logic              tick;

    uart_baud_tick #(
        .BIT_TICKS(BIT_TICKS)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= MSG;
            idx       <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            idx       <= idx_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            tx        <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase;
        idx_next     = idx;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        restart      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    phase_next = MSG;
                    idx_next   = '0;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                case (phase)
                    MSG: begin
                        if (STOP_ON_NUL != 0 && ram_q == 8'h00) begin
                            if (APPEND_CRLF != 0) begin
                                phase_next = CR;
                                state_next = LOAD;
                            end else begin
                                state_next = FINISH;
                            end
                        end else begin
                            shift_next = ram_q;
                            state_next = START_BIT;
                            restart    = 1'b1;
                        end
                    end
                    CR: begin
                        shift_next = CHAR_CR;
                        state_next = START_BIT;
                        restart    = 1'b1;
                    end
                    default: begin
                        shift_next = CHAR_LF;
                        state_next = START_BIT;
                        restart    = 1'b1;
                    end
                endcase
            end
            // Later bit boundaries fall on tick, where the counter wraps
            // itself, so only entry from LOAD needs an explicit restart.
            START_BIT: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP_BIT;
                    end
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    case (phase)
                        MSG: begin
                            if (idx == LAST_IDX) begin
                                if (APPEND_CRLF != 0) begin
                                    phase_next = CR;
                                    state_next = LOAD;
                                end else begin
                                    state_next = FINISH;
                                end
                            end else begin
                                idx_next   = idx + 1'b1;
                                state_next = FETCH;
                            end
                        end
                        CR: begin
                            phase_next = LF;
                            state_next = LOAD;
                        end
                        default: state_next = FINISH;
                    endcase
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // tx is registered from the next-state view so the line changes
        // exactly at the bit boundary with no combinational path to the pin.
        case (state_next)
            START_BIT: tx_next = 1'b0;
            DATA:      tx_next = shift_next[0];
            default:   tx_next = 1'b1;
        endcase
    end

    assign ram_address = idx;
    assign busy        = (state != IDLE) && (state != FINISH);
    assign done        = (state == FINISH);

endmodule

// File: tb/tb_message_uart_tx.sv
// Self-checking bench for message_uart_tx with three configurations:
//   u_a : BIT_TICKS=16, one byte, no NUL stop, no CR/LF
//   u_b : BIT_TICKS=16, four bytes, NUL stop, CR/LF appended
//   u_c : default divider (434 cycles per bit), RAM data always 0x00
module tb_message_uart_tx;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, tx_a, busy_a, done_a;
    logic [4:0] addr_a;
    logic [7:0] ram_q_a;

    logic       start_b, tx_b, busy_b, done_b;
    logic [1:0] addr_b;
    logic [7:0] ram_q_b;
    logic [7:0] mem_b [4];

    logic       start_c, tx_c, busy_c, done_c;
    logic [4:0] addr_c;
    logic [7:0] ram_q_c;

    message_uart_tx #(
        .CLK_FREQ(16), .BAUD(1), .MSG_LEN(1), .ADDR_W(5),
        .STOP_ON_NUL(0), .APPEND_CRLF(0)
    ) u_a (
        .clock(clk), .reset(rst), .start(start_a), .ram_address(addr_a),
        .ram_q(ram_q_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    message_uart_tx #(
        .CLK_FREQ(16), .BAUD(1), .MSG_LEN(4), .ADDR_W(2),
        .STOP_ON_NUL(1), .APPEND_CRLF(1)
    ) u_b (
        .clock(clk), .reset(rst), .start(start_b), .ram_address(addr_b),
        .ram_q(ram_q_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    message_uart_tx #(
        .CLK_FREQ(50000000), .BAUD(115200), .MSG_LEN(32), .ADDR_W(5),
        .STOP_ON_NUL(1), .APPEND_CRLF(1)
    ) u_c (
        .clock(clk), .reset(rst), .start(start_c), .ram_address(addr_c),
        .ram_q(ram_q_c), .tx(tx_c), .busy(busy_c), .done(done_c)
    );

    // Synchronous-read RAM models
    always @(posedge clk) begin
        ram_q_a <= (addr_a == 5'd0) ? 8'h41 : 8'h00;
        ram_q_b <= mem_b[addr_b];
    end
    assign ram_q_c = 8'h00;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receiver for u_b: decodes frames by sampling mid-bit on falling edges
    logic [7:0] rx_q[$];
    int         addr_q[$];
    int         done_b_cnt = 0;
    int         rx_ferr    = 0;
    bit         rx_on      = 1'b0;
    int         rx_n       = 0;
    logic [7:0] rx_sh      = '0;

    always @(negedge clk) begin
        if (done_b) done_b_cnt++;
        if (rst) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (!tx_b) begin
                rx_on = 1'b1;
                rx_n  = 0;
                addr_q.push_back(int'(addr_b));
            end
        end else begin
            rx_n++;
            if (rx_n >= T + T/2 && rx_n < 9*T && ((rx_n - T/2) % T) == 0)
                rx_sh = {tx_b, rx_sh[7:1]};
            if (rx_n == 9*T + T/2) begin
                if (tx_b) rx_q.push_back(rx_sh);
                else rx_ferr++;
                rx_on = 1'b0;
            end
        end
    end

    task automatic pulse_b();
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
    endtask

    task automatic wait_done_b(input string tag);
        int n = 0;
        while (!done_b && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, done_b, 1);
    endtask

    typedef struct {
        int   m;
        logic tx;
        logic busy;
        logic done;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int rx0, dn0, ad0, cur, w, n;
        logic [7:0] exp_abcd[6];
        logic [7:0] exp_nul[4];

        // 0x41 frame: start 0, data LSB first 1,0,0,0,0,0,1,0, stop 1
        vecs[0]  = '{0,   1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1,   1'b1, 1'b1, 1'b0};
        vecs[2]  = '{2,   1'b0, 1'b1, 1'b0};
        vecs[3]  = '{10,  1'b0, 1'b1, 1'b0};
        vecs[4]  = '{26,  1'b1, 1'b1, 1'b0};
        vecs[5]  = '{42,  1'b0, 1'b1, 1'b0};
        vecs[6]  = '{58,  1'b0, 1'b1, 1'b0};
        vecs[7]  = '{74,  1'b0, 1'b1, 1'b0};
        vecs[8]  = '{90,  1'b0, 1'b1, 1'b0};
        vecs[9]  = '{106, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{122, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{138, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{154, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{161, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{162, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{163, 1'b1, 1'b0, 1'b0};

        exp_abcd = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        exp_nul  = '{8'h48, 8'h49, 8'h0D, 8'h0A};

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mem_b[0] = 8'h41; mem_b[1] = 8'h42; mem_b[2] = 8'h43; mem_b[3] = 8'h44;
        #1;
        check("reset_tx",   tx_b,   1);
        check("reset_busy", busy_b, 0);
        check("reset_done", done_b, 0);
        check("reset_addr", addr_b, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single byte frame, table driven
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cur = 0;
        foreach (vecs[i]) begin
            while (cur < vecs[i].m) begin
                @(negedge clk);
                cur++;
            end
            check($sformatf("a_tx@%0d", vecs[i].m),   tx_a,   vecs[i].tx);
            check($sformatf("a_busy@%0d", vecs[i].m), busy_a, vecs[i].busy);
            check($sformatf("a_done@%0d", vecs[i].m), done_a, vecs[i].done);
            check($sformatf("a_addr@%0d", vecs[i].m), addr_a, 0);
        end

        // Default divider: start bit width (NUL data -> CR frame first)
        @(negedge clk) start_c = 1'b1;
        @(negedge clk) start_c = 1'b0;
        n = 0;
        while (tx_c && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c_start_seen", tx_c, 0);
        w = 0;
        while (!tx_c && w < 2000) begin
            w++;
            @(negedge clk);
        end
        check("c_start_width", w, 434);
        n = 0;
        while (!done_c && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("c_done", done_c, 1);

        // Full message with CR/LF plus an ignored start mid-frame
        rx0 = rx_q.size(); ad0 = addr_q.size(); dn0 = done_b_cnt;
        pulse_b();
        repeat (60) @(negedge clk);
        pulse_b();
        wait_done_b("b_done");
        repeat (40) @(negedge clk);
        check("b_idle_after", busy_b, 0);
        check("b_byte_count", rx_q.size() - rx0, 6);
        check("b_done_count", done_b_cnt - dn0, 1);
        for (int i = 0; i < 6; i++) begin
            if (rx0 + i < rx_q.size()) begin
                check($sformatf("b_byte%0d", i), rx_q[rx0 + i], exp_abcd[i]);
                check($sformatf("b_addr%0d", i), addr_q[ad0 + i], (i < 4) ? i : 3);
            end
        end

        // NUL termination
        mem_b[0] = 8'h48; mem_b[1] = 8'h49; mem_b[2] = 8'h00; mem_b[3] = 8'h5A;
        rx0 = rx_q.size(); ad0 = addr_q.size();
        pulse_b();
        wait_done_b("nul_done");
        repeat (4) @(negedge clk);
        check("nul_byte_count", rx_q.size() - rx0, 4);
        for (int i = 0; i < 4; i++) begin
            if (rx0 + i < rx_q.size()) begin
                check($sformatf("nul_byte%0d", i), rx_q[rx0 + i], exp_nul[i]);
                check($sformatf("nul_addr_lt3_%0d", i), addr_q[ad0 + i] < 3, 1);
            end
        end

        // start held high: repeat with one idle cycle between done and FETCH
        rx0 = rx_q.size(); dn0 = done_b_cnt;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk);
        wait_done_b("hold_done1");
        check("hold_finish_busy", busy_b, 0);
        @(negedge clk);
        check("hold_idle_done", done_b, 0);
        check("hold_idle_busy", busy_b, 0);
        check("hold_idle_tx",   tx_b,   1);
        @(negedge clk);
        check("hold_fetch_busy", busy_b, 1);
        check("hold_fetch_addr", addr_b, 0);
        start_b = 1'b0;
        wait_done_b("hold_done2");
        repeat (4) @(negedge clk);
        check("hold_byte_count", rx_q.size() - rx0, 8);
        check("hold_done_count", done_b_cnt - dn0, 2);

        // Asynchronous reset during DATA bit 3 (0x41 bit 3 is 0)
        mem_b[0] = 8'h41;
        pulse_b();
        repeat (74) @(negedge clk);
        check("rst_pre_tx",   tx_b,   0);
        check("rst_pre_busy", busy_b, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_tx",   tx_b,   1);
        check("rst_async_busy", busy_b, 0);
        check("rst_async_done", done_b, 0);
        check("rst_async_addr", addr_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx0 = rx_q.size(); ad0 = addr_q.size();
        pulse_b();
        wait_done_b("rst_after_done");
        repeat (4) @(negedge clk);
        check("rst_after_count", rx_q.size() - rx0, 4);
        if (rx_q.size() > rx0) begin
            check("rst_after_byte0", rx_q[rx0], 8'h41);
            check("rst_after_addr0", addr_q[ad0], 0);
        end
        check("framing_errors", rx_ferr, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
